// File: rtl/uart_frame_builder.sv
// uart_frame_builder
//   Periodically snapshots thirteen BCD-encoded channel voltages and streams
//   them as one ASCII text frame into a downstream UART FIFO, one byte every
//   other cycle at most, stalling while the FIFO reports full.
//
//   Each channel renders as "Cnn:D.DDDV " and the frame ends with CR LF,
//   giving 13 * 11 + 2 = 145 bytes per frame.
//
// Ports
//   clk        : single clock for all logic
//   rst        : synchronous, active-high reset
//   enable     : permission to start a new frame (a running frame always completes)
//   in0..in12  : channel voltages, 4 BCD digits each (volts . tenths hundredths thousandths)
//   tx_full    : downstream FIFO full flag, stalls byte emission
//   w_data     : registered ASCII byte to the FIFO
//   wr_uart    : registered one-cycle write strobe qualifying w_data
//   busy       : high while a frame is being snapshotted or emitted
//   frame_done : one-cycle pulse coincident with the final byte's strobe
module uart_frame_builder #(
  parameter int FRAME_PERIOD = 6500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [15:0] in4,
  input  logic [15:0] in5,
  input  logic [15:0] in6,
  input  logic [15:0] in7,
  input  logic [15:0] in8,
  input  logic [15:0] in9,
  input  logic [15:0] in10,
  input  logic [15:0] in11,
  input  logic [15:0] in12,
  input  logic        tx_full,
  output logic [7:0]  w_data,
  output logic        wr_uart,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_PERIOD - 1);

  // Channel index 13 selects the CR LF trailer.
  localparam logic [3:0] CH_TRAILER = 4'd13;
  localparam logic [3:0] BYTE_LAST  = 4'd10;

  typedef enum logic [1:0] {IDLE, SNAP, EMIT, GAP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   period_cnt;
  logic            tick;
  logic [3:0]      ch_idx, ch_next;
  logic [3:0]      byte_idx, byte_next;
  logic [15:0]     live [13];
  logic [15:0]     snap [13];
  logic [3:0]      ch_sel;
  logic [15:0]     cur_val;
  logic [3:0]      ch_ones;
  logic [7:0]      cur_byte;
  logic [7:0]      w_data_next;
  logic            wr_next;
  logic            done_next;

  function automatic logic [7:0] bcd_char(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
  endfunction

  always_comb begin
    live[0]  = in0;
    live[1]  = in1;
    live[2]  = in2;
    live[3]  = in3;
    live[4]  = in4;
    live[5]  = in5;
    live[6]  = in6;
    live[7]  = in7;
    live[8]  = in8;
    live[9]  = in9;
    live[10] = in10;
    live[11] = in11;
    live[12] = in12;
  end

  assign tick = (period_cnt == CNT_LAST);
  assign busy = (state != IDLE);

  // Byte currently due for emission, formatted from the snapshot only.
  // While in the trailer the channel select is parked at 0 so the array
  // index stays in range.
  always_comb begin
    ch_sel   = (ch_idx < CH_TRAILER) ? ch_idx : 4'd0;
    cur_val  = snap[ch_sel];
    ch_ones  = (ch_idx >= 4'd10) ? (ch_idx - 4'd10) : ch_idx;
    cur_byte = 8'h00;
    if (ch_idx == CH_TRAILER) begin
      cur_byte = (byte_idx == 4'd0) ? 8'h0D : 8'h0A;
    end else begin
      case (byte_idx)
        4'd0:    cur_byte = 8'h43;
        4'd1:    cur_byte = (ch_idx >= 4'd10) ? 8'h31 : 8'h30;
        4'd2:    cur_byte = 8'h30 + {4'h0, ch_ones};
        4'd3:    cur_byte = 8'h3A;
        4'd4:    cur_byte = bcd_char(cur_val[15:12]);
        4'd5:    cur_byte = 8'h2E;
        4'd6:    cur_byte = bcd_char(cur_val[11:8]);
        4'd7:    cur_byte = bcd_char(cur_val[7:4]);
        4'd8:    cur_byte = bcd_char(cur_val[3:0]);
        4'd9:    cur_byte = 8'h56;
        default: cur_byte = 8'h20;
      endcase
    end
  end

  // Next-state and next-output logic. A byte is only emitted from EMIT, and
  // EMIT always hands over to GAP for one cycle, which keeps strobes apart.
  always_comb begin
    state_next  = state;
    ch_next     = ch_idx;
    byte_next   = byte_idx;
    w_data_next = w_data;
    wr_next     = 1'b0;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (tick && enable) state_next = SNAP;
      end
      SNAP: begin
        ch_next    = 4'd0;
        byte_next  = 4'd0;
        state_next = EMIT;
      end
      EMIT: begin
        if (!tx_full) begin
          wr_next     = 1'b1;
          w_data_next = cur_byte;
          state_next  = GAP;
          if (ch_idx == CH_TRAILER) begin
            if (byte_idx == 4'd1) begin
              done_next  = 1'b1;
              state_next = IDLE;
              ch_next    = 4'd0;
              byte_next  = 4'd0;
            end else begin
              byte_next = byte_idx + 4'd1;
            end
          end else if (byte_idx == BYTE_LAST) begin
            byte_next = 4'd0;
            ch_next   = ch_idx + 4'd1;
          end else begin
            byte_next = byte_idx + 4'd1;
          end
        end
      end
      GAP: begin
        state_next = EMIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, indices, snapshot and registered outputs. The period counter
  // free-runs regardless of state so frame starts stay on a fixed grid;
  // ticks arriving while a frame is running are simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      period_cnt <= '0;
      ch_idx     <= 4'd0;
      byte_idx   <= 4'd0;
      w_data     <= 8'h00;
      wr_uart    <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 13; i++) snap[i] <= 16'h0000;
    end else begin
      period_cnt <= tick ? '0 : (period_cnt + 1'b1);
      state      <= state_next;
      ch_idx     <= ch_next;
      byte_idx   <= byte_next;
      w_data     <= w_data_next;
      wr_uart    <= wr_next;
      frame_done <= done_next;
      if (state == SNAP) begin
        for (int i = 0; i < 13; i++) snap[i] <= live[i];
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_builder.sv
// tb_uart_frame_builder
//   Scoreboard bench for uart_frame_builder with FRAME_PERIOD=400. The
//   stimulus process pushes the expected text of each frame (built from the
//   channel values held at frame start) into a queue; a forked monitor pops
//   and compares every byte the DUT strobes out.
module tb_uart_frame_builder;

  localparam int PERIOD = 400;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        tx_full;
  logic [15:0] cur_in [13];
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        busy;
  logic        frame_done;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   cycle;
  int   total_strobes;
  int   frame_strobes;
  int   frames_done;
  int   first_strobe_cycle;

  uart_frame_builder #(.FRAME_PERIOD(PERIOD)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in0        (cur_in[0]),
    .in1        (cur_in[1]),
    .in2        (cur_in[2]),
    .in3        (cur_in[3]),
    .in4        (cur_in[4]),
    .in5        (cur_in[5]),
    .in6        (cur_in[6]),
    .in7        (cur_in[7]),
    .in8        (cur_in[8]),
    .in9        (cur_in[9]),
    .in10       (cur_in[10]),
    .in11       (cur_in[11]),
    .in12       (cur_in[12]),
    .tx_full    (tx_full),
    .w_data     (w_data),
    .wr_uart    (wr_uart),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic string dig(input logic [3:0] d);
    if (d <= 4'd9) return $sformatf("%0d", d);
    return "?";
  endfunction

  // Reference frame: the text the channels should read as, then CR LF.
  task automatic pushFrame();
    string s;
    exp_t  e;
    s = "";
    for (int ch = 0; ch < 13; ch++) begin
      s = {s, $sformatf("C%02d:%s.%s%s%sV ", ch,
                        dig(cur_in[ch][15:12]), dig(cur_in[ch][11:8]),
                        dig(cur_in[ch][7:4]), dig(cur_in[ch][3:0]))};
    end
    s = {s, "\r\n"};
    for (int i = 0; i < s.len(); i++) begin
      e.data = s[i];
      e.last = (i == s.len() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic monitorLoop();
    logic prev_wr;
    exp_t e;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        frame_strobes = 0;
      end else if (wr_uart) begin
        checkOutput("no_back_to_back", {31'd0, prev_wr}, 32'd0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_strobe", {24'd0, w_data}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("byte%0d", frame_strobes), {24'd0, w_data}, {24'd0, e.data});
          checkOutput($sformatf("frame_done_at_byte%0d", frame_strobes), {31'd0, frame_done}, {31'd0, e.last});
        end
        if (frame_strobes == 0) first_strobe_cycle = cycle;
        frame_strobes++;
        total_strobes++;
        if (frame_done) begin
          frames_done++;
          frame_strobes = 0;
        end
      end else if (frame_done) begin
        checkOutput("frame_done_without_strobe", {31'd0, frame_done}, 32'd0);
      end
      prev_wr = wr_uart;
    end
  endtask

  task automatic waitBusy(input int limit, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < limit) begin
      @(negedge clk);
      #1;
      n++;
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // mode 0: plain frame; 1: random stalls and in0 changed mid-frame;
  // 2: 50-cycle stall after byte 10; 3: enable dropped mid-frame;
  // 4: reset pulsed after byte 70.
  task automatic applyStimulus(input string name, input int mode, input int exp_wait);
    int n;
    bit ok;
    int busy_cycle;
    int start_total;
    int start_frames;
    int s;
    bit done;
    bit stalled;
    waitBusy(1000, n, ok);
    if (!ok) begin
      checkOutput({name, "_start_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (exp_wait != 0) checkOutput({name, "_start_wait"}, n, exp_wait);
    busy_cycle   = cycle;
    start_total  = total_strobes;
    start_frames = frames_done;
    pushFrame();
    done    = 1'b0;
    stalled = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (mode == 1) begin
        if (i == 6) cur_in[0] = 16'($urandom);
        if (i >= 10) tx_full = ($urandom_range(0, 3) == 0);
      end
      if (mode == 2 && !stalled && (total_strobes - start_total) == 10) begin
        stalled = 1'b1;
        tx_full = 1'b1;
        s = total_strobes;
        repeat (50) begin
          @(negedge clk);
          #1;
        end
        checkOutput({name, "_no_strobe_in_stall"}, total_strobes - s, 32'd0);
        checkOutput({name, "_busy_in_stall"}, {31'd0, busy}, 32'd1);
        tx_full = 1'b0;
        @(negedge clk);
        #1;
        checkOutput({name, "_resume_strobe"}, {31'd0, wr_uart}, 32'd1);
      end
      if (mode == 3 && i == 20) enable = 1'b0;
      if (mode == 4 && (total_strobes - start_total) == 70) begin
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput({name, "_wr_after_rst"}, {31'd0, wr_uart}, 32'd0);
        checkOutput({name, "_busy_after_rst"}, {31'd0, busy}, 32'd0);
        checkOutput({name, "_done_after_rst"}, {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        return;
      end
      if (frames_done != start_frames) begin
        done = 1'b1;
        break;
      end
    end
    tx_full = 1'b0;
    checkOutput({name, "_completed"}, {31'd0, done}, 32'd1);
    if (done) begin
      checkOutput({name, "_strobe_count"}, total_strobes - start_total, 32'd145);
      checkOutput({name, "_first_byte_latency"}, first_strobe_cycle - busy_cycle, 32'd2);
      checkOutput({name, "_busy_low_after"}, {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic randomInputs();
    for (int i = 0; i < 13; i++) cur_in[i] = 16'($urandom);
  endtask

  initial begin
    int  n;
    bit  ok;
    cycle = 0;
    checks = 0;
    failures = 0;
    total_strobes = 0;
    frame_strobes = 0;
    frames_done = 0;
    first_strobe_cycle = 0;
    rst = 1'b1;
    enable = 1'b1;
    tx_full = 1'b0;
    for (int i = 0; i < 13; i++) cur_in[i] = 16'h0000;
    cur_in[0] = 16'h1234;
    fork
      monitorLoop();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_w_data", {24'd0, w_data}, 32'd0);
    checkOutput("reset_wr_uart", {31'd0, wr_uart}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    $display("[TB] frame with in0=1234");
    applyStimulus("frame_a", 0, PERIOD);

    cur_in[0] = 16'h0000;
    cur_in[5] = 16'h9AF0;
    $display("[TB] frame with invalid digits on in5");
    applyStimulus("frame_b", 0, 0);

    randomInputs();
    $display("[TB] frame with long stall after byte 10");
    applyStimulus("frame_c", 2, 0);

    for (int k = 0; k < 2; k++) begin
      randomInputs();
      $display("[TB] random frame %0d with stalls and mid-frame input change", k);
      applyStimulus($sformatf("frame_rand%0d", k), 1, 0);
    end

    randomInputs();
    $display("[TB] enable dropped mid-frame");
    applyStimulus("frame_e", 3, 0);
    waitBusy(500, n, ok);
    checkOutput("no_start_when_disabled", {31'd0, ok}, 32'd0);
    enable = 1'b1;

    randomInputs();
    $display("[TB] reset pulsed mid-frame");
    applyStimulus("frame_f", 4, 0);

    randomInputs();
    $display("[TB] first frame after reset");
    applyStimulus("frame_g", 0, PERIOD);

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
